// File: rtl/data_bridge.sv
// data_bridge: M-stage data-port responder. Decodes each access to the data
// memory, the countdown timer, or unmapped space. Reads are combinational and
// writes land on the clock edge.
`timescale 1ns/1ps

module data_bridge #(
  parameter int unsigned DM_WORDS = 4096,
  parameter logic [31:0] TMR_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  localparam int unsigned DmAw    = $clog2(DM_WORDS);
  localparam logic [29:0] TmrWord = TMR_BASE[31:2];

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} timerState_t;

  // Address decode
  logic [29:0]     wordAddr;
  logic            dmHit;
  logic            tmrHit;
  logic [1:0]      tmrOff;
  logic [DmAw-1:0] dmIdx;
  logic            anyWrite;
  logic            fullWrite;
  logic            ctrlWr;
  logic            presetWr;
  logic            unusedBits;

  assign wordAddr   = m_data_addr[31:2];
  assign unusedBits = ^m_data_addr[1:0];
  assign dmHit      = wordAddr < 30'(DM_WORDS);
  assign tmrHit     = (wordAddr >= TmrWord) && (wordAddr <= TmrWord + 30'd2);
  assign tmrOff     = 2'(wordAddr - TmrWord);
  assign dmIdx      = wordAddr[DmAw-1:0];
  assign anyWrite   = m_data_byteen != 4'b0000;
  assign fullWrite  = m_data_byteen == 4'b1111;
  assign ctrlWr     = tmrHit && fullWrite && (tmrOff == 2'd0);
  assign presetWr   = tmrHit && fullWrite && (tmrOff == 2'd1);

  // Data memory: storage has no reset; a per-word valid bit makes every word read 0 after reset
  logic [31:0]         dmMem [DM_WORDS];
  logic [DM_WORDS-1:0] dmValid;
  logic [31:0]         dmWord;
  logic [31:0]         mergedWord;

  assign dmWord = dmValid[dmIdx] ? dmMem[dmIdx] : 32'd0;

  // Merge enabled byte lanes over the current word contents
  always_comb begin
    mergedWord = dmWord;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) mergedWord[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  // Memory array write
  always_ff @(posedge clk) begin
    if (reset && dmHit && anyWrite) dmMem[dmIdx] <= mergedWord;
  end

  // Valid bits: cleared on reset, set by any write to the word
  always_ff @(posedge clk) begin
    if (!reset) begin
      dmValid <= '0;
    end else if (dmHit && anyWrite) begin
      dmValid[dmIdx] <= 1'b1;
    end
  end

  // Timer registers and FSM; CPU writes to CTRL/PRESET override the FSM step
  logic        ctrlEn;
  logic [1:0]  ctrlMode;
  logic        ctrlIm;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irqFlag;
  timerState_t state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrlEn   <= 1'b0;
      ctrlMode <= 2'b00;
      ctrlIm   <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irqFlag  <= 1'b0;
      state    <= StIdle;
    end else if (ctrlWr || presetWr) begin
      if (ctrlWr) begin
        ctrlEn   <= m_data_wdata[0];
        ctrlMode <= m_data_wdata[2:1];
        ctrlIm   <= m_data_wdata[3];
      end
      if (presetWr) preset <= m_data_wdata;
      irqFlag <= 1'b0;
      state   <= StIdle;
    end else begin
      case (state)
        StIdle: begin
          if (ctrlEn) state <= StLoad;
        end
        StLoad: begin
          count <= preset;
          state <= StCnt;
        end
        StCnt: begin
          if (!ctrlEn) begin
            state <= StIdle;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count   <= 32'd0;
            irqFlag <= 1'b1;
            state   <= StInt;
          end
        end
        StInt: begin
          if (ctrlMode == 2'b01) begin
            irqFlag <= 1'b0;
            state   <= StLoad;
          end else begin
            ctrlEn <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign irq = irqFlag & ctrlIm;

  // Read mux: unmapped space and the unused timer slot read as zero
  always_comb begin
    m_data_rdata = 32'd0;
    if (dmHit) begin
      m_data_rdata = dmWord;
    end else if (tmrHit) begin
      case (tmrOff)
        2'd0:    m_data_rdata = {28'd0, ctrlIm, ctrlMode, ctrlEn};
        2'd1:    m_data_rdata = preset;
        2'd2:    m_data_rdata = count;
        default: m_data_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bridge.sv
// tb_data_bridge: directed checks of data_bridge with an expected-value queue.
`timescale 1ns/1ps

module tb_data_bridge;

  localparam logic [31:0] CtrlA   = 32'h0000_7F00;
  localparam logic [31:0] PresetA = 32'h0000_7F04;
  localparam logic [31:0] CountA  = 32'h0000_7F08;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] expQ[$];
  string       tagQ[$];

  logic [31:0] arCount [8] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
  logic        arIrq   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  data_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .irq           (irq)
  );

  always #50 clk = ~clk;

  // Pop the oldest expectation and compare against the observed value
  task automatic popCmp(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic checkRd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    m_data_addr = addr;
    #1;
    popCmp(m_data_rdata);
  endtask

  task automatic checkIrq(input logic exp, input string tag);
    expQ.push_back({31'd0, exp});
    tagQ.push_back(tag);
    #1;
    popCmp({31'd0, irq});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a write for one edge; returns just after that edge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    m_data_addr   = addr;
    m_data_wdata  = data;
    m_data_byteen = be;
    @(posedge clk);
    #1;
    m_data_byteen = 4'b0000;
  endtask

  initial begin
    reset         = 1'b0;
    m_data_addr   = 32'd0;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'b0000;
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(1);

    // Reset state
    checkRd(32'h0000_0000, 32'd0, "rst_dm0");
    checkRd(32'h0000_0010, 32'd0, "rst_dm10");
    checkRd(CtrlA,   32'd0, "rst_ctrl");
    checkRd(PresetA, 32'd0, "rst_preset");
    checkRd(CountA,  32'd0, "rst_count");
    checkIrq(1'b0, "rst_irq");

    // DM byte lanes
    wr(32'h10, 32'h1122_3344, 4'b1111);
    checkRd(32'h10, 32'h1122_3344, "dm_full");
    wr(32'h10, 32'h0000_AB00, 4'b0010);
    checkRd(32'h10, 32'h1122_AB44, "dm_lane1");

    // Read and write of the same word in one cycle sees the old value
    @(negedge clk);
    m_data_wdata  = 32'hDEAD_BEEF;
    m_data_byteen = 4'b1111;
    checkRd(32'h10, 32'h1122_AB44, "dm_same_cycle_old");
    tick(1);
    m_data_byteen = 4'b0000;
    checkRd(32'h10, 32'hDEAD_BEEF, "dm_next_cycle_new");

    // Last DM word and first address past it
    wr(32'h3FFC, 32'hA5A5_5A5A, 4'b1111);
    checkRd(32'h3FFC, 32'hA5A5_5A5A, "dm_last_word");
    wr(32'h4000, 32'h1234_5678, 4'b1111);
    checkRd(32'h4000, 32'd0, "unmapped_after_dm");
    checkRd(32'h0, 32'd0, "dm0_untouched");

    // Unmapped and timer partial writes
    wr(32'h5000, 32'hFFFF_FFFF, 4'b1111);
    checkRd(32'h5000, 32'd0, "unmapped_5000");
    wr(CtrlA, 32'h0000_000F, 4'b0011);
    checkRd(CtrlA, 32'd0, "ctrl_partial");
    wr(PresetA, 32'h0000_0077, 4'b0001);
    checkRd(PresetA, 32'd0, "preset_partial");
    wr(CountA, 32'h0000_1234, 4'b1111);
    checkRd(CountA, 32'd0, "count_readonly");
    wr(CtrlA, 32'hFFFF_FFF0, 4'b1111);
    checkRd(CtrlA, 32'd0, "ctrl_upper_bits");

    // One-shot, PRESET=3, CTRL=0x9 at edge k
    wr(PresetA, 32'd3, 4'b1111);
    checkRd(PresetA, 32'd3, "os_preset");
    wr(CtrlA, 32'h9, 4'b1111);
    tick(1);
    checkRd(CountA, 32'd0, "os_k1_count");
    tick(1);
    checkRd(CountA, 32'd3, "os_k2_count");
    tick(1);
    checkRd(CountA, 32'd2, "os_k3_count");
    tick(1);
    checkRd(CountA, 32'd1, "os_k4_count");
    checkIrq(1'b0, "os_k4_irq");
    tick(1);
    checkRd(CountA, 32'd0, "os_k5_count");
    checkIrq(1'b1, "os_k5_irq");
    tick(1);
    checkRd(CtrlA, 32'h8, "os_k6_ctrl");
    checkIrq(1'b1, "os_k6_irq");
    tick(3);
    checkIrq(1'b1, "os_irq_held");
    checkRd(CountA, 32'd0, "os_count_idle");
    wr(CtrlA, 32'h0, 4'b1111);
    checkIrq(1'b0, "os_irq_cleared");

    // Auto-reload, PRESET=2, CTRL=0xB
    wr(PresetA, 32'd2, 4'b1111);
    wr(CtrlA, 32'hB, 4'b1111);
    tick(1);
    for (int j = 0; j < 8; j++) begin
      tick(1);
      checkRd(CountA, arCount[j], $sformatf("ar_count_%0d", j));
      checkIrq(arIrq[j], $sformatf("ar_irq_%0d", j));
    end
    checkRd(CtrlA, 32'hB, "ar_ctrl_kept");
    tick(1);
    checkRd(CountA, 32'd2, "ar_reloaded");

    // Clear EN mid-count: count freezes, state idles
    wr(CtrlA, 32'h8, 4'b1111);
    checkRd(CountA, 32'd2, "stop_count");
    checkIrq(1'b0, "stop_irq");
    tick(3);
    checkRd(CountA, 32'd2, "stop_frozen");
    checkIrq(1'b0, "stop_irq_later");

    // PRESET write on the cycle CNT would expire
    wr(PresetA, 32'd3, 4'b1111);
    wr(CtrlA, 32'h9, 4'b1111);
    tick(4);
    checkRd(CountA, 32'd1, "pw_k4_count");
    wr(PresetA, 32'd5, 4'b1111);
    checkRd(CountA, 32'd1, "pw_k5_count");
    checkIrq(1'b0, "pw_k5_irq");
    tick(1);
    checkRd(CountA, 32'd1, "pw_k6_count");
    checkIrq(1'b0, "pw_k6_irq");
    tick(1);
    checkRd(CountA, 32'd5, "pw_k7_count");
    tick(1);
    checkRd(CountA, 32'd4, "pw_k8_count");
    tick(4);
    checkIrq(1'b1, "pw_k12_irq");
    checkRd(CountA, 32'd0, "pw_k12_count");

    // Reset with irq high and DM populated
    checkRd(32'h10, 32'hDEAD_BEEF, "pre_rst_dm");
    @(negedge clk);
    reset = 1'b0;
    checkIrq(1'b1, "irq_before_rst_edge");
    tick(1);
    checkIrq(1'b0, "mrst_irq");
    checkRd(32'h10, 32'd0, "mrst_dm10");
    checkRd(32'h3FFC, 32'd0, "mrst_dm_last");
    checkRd(CountA, 32'd0, "mrst_count");
    checkRd(CtrlA, 32'd0, "mrst_ctrl");
    @(negedge clk);
    reset = 1'b1;
    checkRd(PresetA, 32'd0, "mrst_preset");
    tick(5);
    checkRd(CountA, 32'd0, "post_rst_idle_count");
    checkIrq(1'b0, "post_rst_irq");
    wr(PresetA, 32'd2, 4'b1111);
    tick(4);
    checkRd(PresetA, 32'd2, "post_rst_preset");
    checkRd(CountA, 32'd0, "post_rst_no_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bridge.md
# data_bridge

Memory-side responder for the CPU data port: it serves `m_data_addr`/`m_data_wdata`/`m_data_byteen` and returns `m_data_rdata` in the same cycle.
- Decodes each access to one of three targets: the on-chip data memory, a programmable countdown timer, or unmapped space.
- Sits between the pipeline's M stage and the memory/peripheral fabric.
- Raises `irq` when the timer expires.

## Interface
- `DM_WORDS`, 4096: data-memory depth in 32-bit words; mapped at byte addresses 0x0000_0000 to 4*DM_WORDS-1.
- `TMR_BASE`, 32'h0000_7F00: timer base address; CTRL at +0x0, PRESET at +0x4, COUNT at +0x8.
- `clk` input 1: single clock. All state updates on posedge.
- `reset` input 1: synchronous, active-low. `reset==0` at a posedge clears all state.
- `m_data_addr` input 32: access byte address (word-aligned for reads).
- `m_data_wdata` input 32: write data, already lane-positioned.
- `m_data_byteen` input 4: per-byte write enables. `4'b0000` means a read or no access.
- `m_data_rdata` output 32: read data, combinational from address.
- `irq` output 1: timer interrupt request.

## Operation
- Decode uses `m_data_addr[31:2]`:
  - DM hit when the address is below 4*DM_WORDS.
  - Timer hit when the address is in TMR_BASE..TMR_BASE+0xB.
  - Everything else is unmapped.
- DM write: each byte lane `i` with `byteen[i]=1` stores `wdata[8i+7:8i]`; other lanes are unchanged.
- DM read returns the full word. Lane extraction is done by the CPU.
- Timer register writes are accepted only when `byteen==4'b1111`. Partial writes to the timer are ignored.
  - CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask/enable). Bits [31:4] read as 0 and are not stored.
  - PRESET: fully read/write.
  - COUNT: read-only. Writes are ignored.
- Unmapped space: reads return 0, writes are ignored, no error is flagged.
- Timer FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if !EN, go to IDLE (COUNT holds). Else if COUNT>1, COUNT <= COUNT-1. Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 00: EN <= 0, go to IDLE, irq_flag held.
  - INT, MODE 01: irq_flag <= 0, go to LOAD.
- `irq = irq_flag & CTRL.IM`.
- CPU write to CTRL or PRESET in any cycle has priority over the FSM:
  - the register takes the written value;
  - the state goes to IDLE;
  - irq_flag is cleared;
  - the FSM's own update that cycle is discarded.
- Arithmetic: COUNT is 32-bit unsigned and never wraps below 0. PRESET of 0 or 1 expires on the first CNT cycle.

## Timing
- Reset values:
  - all DM words 0;
  - CTRL, PRESET, COUNT 0;
  - state IDLE;
  - irq_flag 0, so `irq`=0;
  - `m_data_rdata` = 0 for any address immediately after reset.
- Read latency is 0 cycles: `m_data_rdata` follows `m_data_addr` combinationally.
- Write latency is 1 edge: a read in the cycle after the write edge returns the new value.
- A read and a write to the same address in the same cycle returns the old value.
- Timer with PRESET=N≥2, CTRL written with EN=1 at edge k:
  - IDLE→LOAD at k+1;
  - COUNT=N and state CNT after k+2;
  - COUNT=1 after k+N+1;
  - irq_flag=1 and COUNT=0 after k+N+2;
  - MODE 00: IDLE with EN=0 after k+N+3, irq held until the next CTRL/PRESET write;
  - MODE 01: irq_flag high for exactly one cycle, COUNT=N again after k+N+4, period N+2.
- Clearing EN mid-count (CTRL write): IDLE at the next edge, COUNT frozen, `irq` low.
- `reset==0` mid-count: all state returns to reset values at that edge, and `irq` drops in the same cycle it is sampled.

## Test plan
- DM byte lanes:
  - write 0x11223344 to 0x10 with byteen 1111;
  - then write 0x0000AB00 with byteen 0010;
  - read 0x10 → 0x1122AB44.
- Unmapped/timer partial write:
  - write 0xFFFFFFFF to 0x5000 → read 0x5000 gives 0;
  - write CTRL with byteen 0011 → CTRL stays 0;
  - write COUNT → read COUNT unchanged.
- One-shot, PRESET=3, CTRL=0x9 at edge k:
  - COUNT reads 3, 2, 1 after k+2..k+4;
  - `irq`=1 from k+5 onward;
  - CTRL reads 0x8 after k+6;
  - writing CTRL=0 clears `irq` at the next edge.
- Auto-reload, PRESET=2, CTRL=0xB:
  - `irq` pulses one cycle every 4 cycles;
  - COUNT sequence 2, 1, 0, 0, 2, 1, …
- Write PRESET=5 in the same cycle CNT would expire: state goes IDLE, no `irq` pulse, and with EN still 1 the timer restarts with COUNT=5.
- Pull `reset` low with `irq`=1 and DM holding data: the next cycle reads all zeros and `irq`=0. Releasing reset leaves the timer idle until CTRL is written.
